realtank_busmtx_input_stage: RTL and testbench
==============================================

Name: realtank_busmtx_input_stage

Overview:
- Per-master AHB input stage of the RealTankSoC bus matrix. It sits between a master port and that port's address decoder.
- Captures an address phase into a holding register when the selected output stage cannot accept it, and stalls the master until the transfer is issued.
- Drives the decoder's sel/addr/trans inputs and returns the decoder's ready/resp to the master.
- Ensures no address phase is lost while output stages arbitrate between masters.

Parameters:
AUSER_W, 32, width of HAUSERS / auser_op
MASTER_ID, 0, constant identifying this master port (driven on master_op)

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  port select from master
HADDRS  in  32  address
HTRANSS  in  2  transfer type
HWRITES  in  1  write
HSIZES  in  3  size
HBURSTS  in  3  burst
HPROTS  in  4  protection
HMASTLOCKS  in  1  locked transfer
HAUSERS  in  AUSER_W  address user
HREADYS  in  1  master-side HREADY
active_dec  in  1  decoder: selected output stage is serving this port
readyout_dec  in  1  decoder HREADYOUT (data-phase)
resp_dec  in  2  decoder HRESP (data-phase)
sel_dec  out  1  select to decoder
decode_addr_dec  out  22  address [31:10] to decoder
addr_op  out  32  full address to output stages
trans_dec  out  2  HTRANS to decoder/output stages
write_op, size_op, burst_op, prot_op, mastlock_op, auser_op  out  1/3/3/4/1/AUSER_W  muxed control
master_op  out  4  MASTER_ID
held_tran_op  out  1  holding register valid
HREADYOUTS  out  1  ready to master
HRESPS  out  2  response to master

Behaviour:
- Clock and reset: HCLK; HRESETn asynchronous, active-low.
- Reset: held_q=0, dphase_q=0, holding registers all 0, HREADYOUTS=1, HRESPS=OKAY(00).
- accept = HSELS & HTRANSS[1] & HREADYS.
- Live issue (accept & active_dec): address phase goes straight through; dphase_q<=1 next cycle; no holding.
- Load (accept & ~active_dec):
  - Capture HADDRS..HAUSERS into holding registers; held_q<=1.
  - If HTRANSS=SEQ, store trans as NONSEQ and burst as INCR (001), because an arbitration gap breaks burst continuity.
- Held issue: when held_q & active_dec & readyout_dec, the held address phase completes; held_q<=0, dphase_q<=1.
- held_q and dphase_q are never both 1 (assertion).
- dphase_q clears when readyout_dec=1 and no live/held issue occurs in the same cycle. A new issue while readyout_dec=1 keeps it at 1 (back-to-back transfers).
- Output mux:
  - When held_q=1: sel_dec=1, and all address/control outputs come from the holding registers.
  - Otherwise: sel_dec=HSELS, outputs are the live bus, and trans_dec=IDLE when HSELS=0.
  - decode_addr_dec = addr_op[31:10].
- HREADYOUTS: held_q → 0; else dphase_q → readyout_dec; else 1.
- HRESPS: dphase_q → resp_dec; else OKAY.
- ERROR is two-cycle pass-through (ready 0/ERR, then 1/ERR). A master IDLE after ERROR is passed through live, with no special handling.
- Master-driven BUSY/IDLE never loads the holding register.
- Lock: mastlock_op follows the muxed source. Lock-hold of the output stage is the output stage's responsibility.
- Reset asserted mid-held or mid-data-phase drops the pending transfer. There is no replay.

Decomposition:
- Shared package realtank_busmtx_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST_INCR, HRESP_OKAY/ERROR, address-region constants also used by the decoders.
- No sub-module. The holding register is a single always block.

Test Plan:
- Live NONSEQ read at 0x0000_1000 with active_dec=1 → no hold; sel_dec=1, decode_addr_dec=0x000004; HREADYOUTS follows readyout_dec next cycle.
- NONSEQ at 0x1000_0000 with active_dec=0 for 3 cycles → held_tran_op=1, HREADYOUTS=0 for 3 cycles; addr_op stays 0x1000_0000 while HADDRS changes; issues on the cycle active_dec=1.
- SEQ beat of INCR4 held → trans_dec=NONSEQ (10), burst_op=INCR (001) while held; the next live SEQ passes unchanged.
- Data-phase ERROR: readyout_dec 0→1 with resp_dec=01 → HREADYOUTS 0,1 and HRESPS 01,01; then IDLE gives OKAY, ready=1.
- HRESETn pulsed low while held_q=1 → held_tran_op=0, HREADYOUTS=1, HRESPS=00 immediately (async).
- Back-to-back live transfers with readyout_dec=1 → dphase_q stays 1, one transfer per cycle, zero wait states.

Source files
------------

// File: rtl/realtank_busmtx_pkg.sv
// Shared definitions for the RealTankSoC bus matrix: AHB encodings,
// decoder address-region constants and input-stage state encoding.
package realtank_busmtx_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encoding used when a held SEQ beat is re-issued stand-alone
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  // HRESP encodings
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Address region decoding: decoders only look at address bits [31:10]
  localparam int unsigned DECODE_ADDR_LSB = 10;
  localparam int unsigned DECODE_ADDR_W   = 22;

  // Input stage state: held address phase and data phase are exclusive
  typedef enum logic [1:0] {
    IS_IDLE   = 2'b00,
    IS_HELD   = 2'b01,
    IS_DPHASE = 2'b10
  } is_state_t;

  // NONSEQ and SEQ are the only transfer types that carry an address phase
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/realtank_busmtx_input_stage_chk.sv
// Property checker for the bus matrix input stage: a held address phase
// and an outstanding data phase must never coexist.
module realtank_busmtx_input_stage_chk (
  input logic HCLK,
  input logic HRESETn,
  input logic i_held_q,
  input logic i_dphase_q
);

  a_held_dphase_excl : assert property (
    @(posedge HCLK) disable iff (!HRESETn) !(i_held_q && i_dphase_q)
  ) else $error("input stage: held and data phase set together");

endmodule

// File: rtl/realtank_busmtx_input_stage.sv
// Per-master AHB input stage of the RealTankSoC bus matrix. Holds an
// address phase while the selected output stage is busy and stalls the
// master until the held transfer has been issued.
module realtank_busmtx_input_stage
  import realtank_busmtx_pkg::*;
#(
  parameter int unsigned AUSER_W   = 32,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELS,
  input  logic [31:0]        HADDRS,
  input  logic [1:0]         HTRANSS,
  input  logic               HWRITES,
  input  logic [2:0]         HSIZES,
  input  logic [2:0]         HBURSTS,
  input  logic [3:0]         HPROTS,
  input  logic               HMASTLOCKS,
  input  logic [AUSER_W-1:0] HAUSERS,
  input  logic               HREADYS,
  input  logic               active_dec,
  input  logic               readyout_dec,
  input  logic [1:0]         resp_dec,
  output logic               sel_dec,
  output logic [21:0]        decode_addr_dec,
  output logic [31:0]        addr_op,
  output logic [1:0]         trans_dec,
  output logic               write_op,
  output logic [2:0]         size_op,
  output logic [2:0]         burst_op,
  output logic [3:0]         prot_op,
  output logic               mastlock_op,
  output logic [AUSER_W-1:0] auser_op,
  output logic [3:0]         master_op,
  output logic               held_tran_op,
  output logic               HREADYOUTS,
  output logic [1:0]         HRESPS
);

  is_state_t r_state;
  is_state_t w_state_nxt;

  logic [31:0]        r_addr;
  logic [1:0]         r_trans;
  logic               r_write;
  logic [2:0]         r_size;
  logic [2:0]         r_burst;
  logic [3:0]         r_prot;
  logic               r_lock;
  logic [AUSER_W-1:0] r_auser;

  logic w_accept;
  logic w_live_issue;
  logic w_load;
  logic w_held_issue;
  logic w_held_q;
  logic w_dphase_q;

  // A new address phase is presented only while no transfer is being held
  assign w_accept     = HSELS & is_active_trans(HTRANSS) & HREADYS;
  assign w_held_q     = (r_state == IS_HELD);
  assign w_dphase_q   = (r_state == IS_DPHASE);
  assign w_live_issue = w_accept & active_dec & ~w_held_q;
  assign w_load       = w_accept & ~active_dec & ~w_held_q;
  assign w_held_issue = w_held_q & active_dec & readyout_dec;

  // State register: idle / holding an address phase / in a data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: issues start a data phase, a blocked accept is held
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IS_IDLE: begin
        if (w_live_issue) begin
          w_state_nxt = IS_DPHASE;
        end else if (w_load) begin
          w_state_nxt = IS_HELD;
        end else begin
          w_state_nxt = IS_IDLE;
        end
      end
      IS_HELD: begin
        if (w_held_issue) begin
          w_state_nxt = IS_DPHASE;
        end else begin
          w_state_nxt = IS_HELD;
        end
      end
      IS_DPHASE: begin
        if (w_live_issue) begin
          w_state_nxt = IS_DPHASE;
        end else if (w_load) begin
          w_state_nxt = IS_HELD;
        end else if (readyout_dec) begin
          w_state_nxt = IS_IDLE;
        end else begin
          w_state_nxt = IS_DPHASE;
        end
      end
      default: begin
        w_state_nxt = IS_IDLE;
      end
    endcase
  end

  // Master-side handshake: stall while holding, pass data-phase ready/resp
  always_comb begin
    held_tran_op = w_held_q;
    HREADYOUTS   = 1'b1;
    HRESPS       = HRESP_OKAY;
    if (w_held_q) begin
      HREADYOUTS = 1'b0;
    end else if (w_dphase_q) begin
      HREADYOUTS = readyout_dec;
    end else begin
      HREADYOUTS = 1'b1;
    end
    if (w_dphase_q) begin
      HRESPS = resp_dec;
    end else begin
      HRESPS = HRESP_OKAY;
    end
  end

  // Holding register: capture the blocked address phase; a SEQ beat becomes
  // a stand-alone INCR NONSEQ since the arbitration gap breaks the burst
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= 32'h0000_0000;
      r_trans <= HTRANS_IDLE;
      r_write <= 1'b0;
      r_size  <= 3'b000;
      r_burst <= 3'b000;
      r_prot  <= 4'b0000;
      r_lock  <= 1'b0;
      r_auser <= {AUSER_W{1'b0}};
    end else if (w_load) begin
      r_addr  <= HADDRS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_prot  <= HPROTS;
      r_lock  <= HMASTLOCKS;
      r_auser <= HAUSERS;
      if (HTRANSS == HTRANS_SEQ) begin
        r_trans <= HTRANS_NONSEQ;
        r_burst <= HBURST_INCR;
      end else begin
        r_trans <= HTRANSS;
        r_burst <= HBURSTS;
      end
    end
  end

  // Address/control mux towards decoder and output stages
  always_comb begin
    master_op = 4'(MASTER_ID);
    if (w_held_q) begin
      sel_dec     = 1'b1;
      addr_op     = r_addr;
      trans_dec   = r_trans;
      write_op    = r_write;
      size_op     = r_size;
      burst_op    = r_burst;
      prot_op     = r_prot;
      mastlock_op = r_lock;
      auser_op    = r_auser;
    end else begin
      sel_dec     = HSELS;
      addr_op     = HADDRS;
      trans_dec   = HSELS ? HTRANSS : HTRANS_IDLE;
      write_op    = HWRITES;
      size_op     = HSIZES;
      burst_op    = HBURSTS;
      prot_op     = HPROTS;
      mastlock_op = HMASTLOCKS;
      auser_op    = HAUSERS;
    end
  end

  assign decode_addr_dec = addr_op[31:DECODE_ADDR_LSB];

endmodule

// File: tb/tb_realtank_busmtx_input_stage.sv
// Self-checking bench for realtank_busmtx_input_stage: per-feature tasks with
// inline checks plus a scoreboard of issued address phases.
module tb_realtank_busmtx_input_stage;
  import realtank_busmtx_pkg::*;

  localparam int AUSER_W = 32;

  typedef struct packed {
    logic [31:0]        addr;
    logic [1:0]         trans;
    logic [2:0]         burst;
    logic               write;
    logic [AUSER_W-1:0] auser;
  } xfer_t;

  logic HCLK, HRESETn, HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic [AUSER_W-1:0] HAUSERS;
  logic active_dec, readyout_dec;
  logic [1:0] resp_dec;
  logic sel_dec, write_op, mastlock_op, held_tran_op, HREADYOUTS;
  logic [21:0] decode_addr_dec;
  logic [31:0] addr_op;
  logic [1:0]  trans_dec, HRESPS;
  logic [2:0]  size_op, burst_op;
  logic [3:0]  prot_op, master_op;
  logic [AUSER_W-1:0] auser_op;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  xfer_t cur, e, o;
  int n_checks = 0;
  int n_fail   = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single-slave bus: the master sees the stage's own HREADYOUT
  assign HREADYS = HREADYOUTS;

  realtank_busmtx_input_stage #(.AUSER_W(AUSER_W), .MASTER_ID(5)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS), .HREADYS(HREADYS),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec), .addr_op(addr_op),
    .trans_dec(trans_dec), .write_op(write_op), .size_op(size_op),
    .burst_op(burst_op), .prot_op(prot_op), .mastlock_op(mastlock_op),
    .auser_op(auser_op), .master_op(master_op), .held_tran_op(held_tran_op),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  bind realtank_busmtx_input_stage realtank_busmtx_input_stage_chk u_chk (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_held_q(w_held_q), .i_dphase_q(w_dphase_q)
  );

  // Record every address phase the output stage takes on the coming edge
  always @(negedge HCLK) begin
    if (HRESETn && sel_dec && trans_dec[1] && active_dec &&
        (held_tran_op ? readyout_dec : HREADYS)) begin
      obs_q.push_back({addr_op, trans_dec, burst_op, write_op, auser_op});
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_idle();
    HSELS = 1'b0; HADDRS = 32'h0; HTRANSS = HTRANS_IDLE; HWRITES = 1'b0;
    HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
    HAUSERS = '0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t,
                       input logic [2:0] b, input logic w, input logic [31:0] u);
    HSELS = 1'b1; HADDRS = a; HTRANSS = t; HBURSTS = b; HWRITES = w; HAUSERS = u;
    cur = {a, t, b, w, u};
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; set_idle();
    active_dec = 1'b0; readyout_dec = 1'b0; resp_dec = HRESP_ERROR;
    repeat (2) @(posedge HCLK);
    #1;
    n_checks++;
    if (held_tran_op !== 1'b0 || HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: observed held=%b ready=%b resp=%b required 0 1 00",
               held_tran_op, HREADYOUTS, HRESPS);
    end
    n_checks++;
    if (sel_dec !== 1'b0 || trans_dec !== 2'b00 || master_op !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_outputs: observed sel=%b trans=%b master=%0d required 0 00 5",
               sel_dec, trans_dec, master_op);
    end
    readyout_dec = 1'b1; resp_dec = HRESP_OKAY;
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_live();
    drive(32'h0000_1000, HTRANS_NONSEQ, 3'b000, 1'b0, 32'h0000_0011);
    active_dec = 1'b1; readyout_dec = 1'b1;
    exp_q.push_back(cur);
    #1;
    n_checks++;
    if (sel_dec !== 1'b1 || decode_addr_dec !== 22'h000004 || held_tran_op !== 1'b0 ||
        trans_dec !== 2'b10) begin
      n_fail++;
      $display("FAIL live_addr: observed sel=%b dec=%h held=%b trans=%b required 1 000004 0 10",
               sel_dec, decode_addr_dec, held_tran_op, trans_dec);
    end
    tick();
    set_idle(); readyout_dec = 1'b0;
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b0) begin
      n_fail++; $display("FAIL live_wait: observed ready=%b required 0", HREADYOUTS);
    end
    tick();
    readyout_dec = 1'b1;
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b1) begin
      n_fail++; $display("FAIL live_done: observed ready=%b required 1", HREADYOUTS);
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL live_sb: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL live_sb: observed %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL live_extra: observed %0d extra required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_hold();
    drive(32'h1000_0000, HTRANS_NONSEQ, 3'b000, 1'b1, 32'hA5A5_0001);
    active_dec = 1'b0; readyout_dec = 1'b1;
    exp_q.push_back(cur);
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b1 || held_tran_op !== 1'b0) begin
      n_fail++; $display("FAIL hold_load: observed ready=%b held=%b required 1 0",
                         HREADYOUTS, held_tran_op);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      HTRANSS = HTRANS_IDLE; HADDRS = 32'hDEAD_0000 + 32'(k);
      active_dec = (k == 3);
      #1;
      n_checks++;
      if (held_tran_op !== 1'b1 || HREADYOUTS !== 1'b0 || addr_op !== 32'h1000_0000 ||
          trans_dec !== 2'b10 || sel_dec !== 1'b1 || write_op !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: observed held=%b ready=%b addr=%h trans=%b sel=%b wr=%b required 1 0 10000000 10 1 1",
                 k, held_tran_op, HREADYOUTS, addr_op, trans_dec, sel_dec, write_op);
      end
      tick();
    end
    set_idle(); active_dec = 1'b0;
    #1;
    n_checks++;
    if (held_tran_op !== 1'b0 || HREADYOUTS !== 1'b1) begin
      n_fail++; $display("FAIL hold_issued: observed held=%b ready=%b required 0 1",
                         held_tran_op, HREADYOUTS);
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL hold_sb: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL hold_sb: observed %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL hold_extra: observed %0d extra required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_seq_hold();
    drive(32'h2000_0004, HTRANS_SEQ, 3'b011, 1'b1, 32'h0000_0777);
    active_dec = 1'b0; readyout_dec = 1'b1;
    exp_q.push_back({32'h2000_0004, HTRANS_NONSEQ, HBURST_INCR, 1'b1, 32'h0000_0777});
    #1;
    n_checks++;
    if (trans_dec !== 2'b11 || burst_op !== 3'b011) begin
      n_fail++; $display("FAIL seq_live_pre: observed trans=%b burst=%b required 11 011",
                         trans_dec, burst_op);
    end
    tick();
    HTRANSS = HTRANS_IDLE;
    #1;
    n_checks++;
    if (trans_dec !== 2'b10 || burst_op !== 3'b001 || held_tran_op !== 1'b1) begin
      n_fail++; $display("FAIL seq_held: observed trans=%b burst=%b held=%b required 10 001 1",
                         trans_dec, burst_op, held_tran_op);
    end
    tick();
    active_dec = 1'b1;
    tick();
    drive(32'h2000_0008, HTRANS_SEQ, 3'b011, 1'b1, 32'h0000_0778);
    exp_q.push_back(cur);
    #1;
    n_checks++;
    if (trans_dec !== 2'b11 || burst_op !== 3'b011 || held_tran_op !== 1'b0) begin
      n_fail++; $display("FAIL seq_live_post: observed trans=%b burst=%b held=%b required 11 011 0",
                         trans_dec, burst_op, held_tran_op);
    end
    tick();
    set_idle(); active_dec = 1'b0;
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL seq_sb: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL seq_sb: observed %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL seq_extra: observed %0d extra required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_error();
    drive(32'h4000_0000, HTRANS_NONSEQ, 3'b000, 1'b0, 32'h0000_0042);
    active_dec = 1'b1; readyout_dec = 1'b1;
    exp_q.push_back(cur);
    tick();
    set_idle(); active_dec = 1'b0; readyout_dec = 1'b0; resp_dec = HRESP_ERROR;
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin
      n_fail++; $display("FAIL err_cycle1: observed ready=%b resp=%b required 0 01", HREADYOUTS, HRESPS);
    end
    tick();
    readyout_dec = 1'b1;
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin
      n_fail++; $display("FAIL err_cycle2: observed ready=%b resp=%b required 1 01", HREADYOUTS, HRESPS);
    end
    tick();
    #1;
    n_checks++;
    if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
      n_fail++; $display("FAIL err_after: observed ready=%b resp=%b required 1 00", HREADYOUTS, HRESPS);
    end
    resp_dec = HRESP_OKAY;
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL err_sb: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL err_sb: observed %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_busy_idle();
    drive(32'h5000_0000, HTRANS_BUSY, 3'b011, 1'b0, 32'h0);
    active_dec = 1'b0;
    tick();
    n_checks++;
    if (held_tran_op !== 1'b0) begin
      n_fail++; $display("FAIL busy_noload: observed held=%b required 0", held_tran_op);
    end
    HSELS = 1'b0; HTRANSS = HTRANS_NONSEQ;
    #1;
    n_checks++;
    if (sel_dec !== 1'b0 || trans_dec !== 2'b00) begin
      n_fail++; $display("FAIL unsel_idle: observed sel=%b trans=%b required 0 00", sel_dec, trans_dec);
    end
    tick();
    n_checks++;
    if (held_tran_op !== 1'b0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL unsel_noload: observed held=%b issues=%0d required 0 0",
                         held_tran_op, obs_q.size());
      obs_q.delete();
    end
    set_idle();
  endtask

  task automatic test_reset_held();
    drive(32'h6000_0000, HTRANS_NONSEQ, 3'b000, 1'b0, 32'h1);
    active_dec = 1'b0;
    tick();
    HTRANSS = HTRANS_IDLE; readyout_dec = 1'b0; resp_dec = HRESP_ERROR;
    n_checks++;
    if (held_tran_op !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: observed held=%b required 1", held_tran_op);
    end
    #1 HRESETn = 1'b0;
    #1;
    n_checks++;
    if (held_tran_op !== 1'b0 || HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
      n_fail++; $display("FAIL rst_async: observed held=%b ready=%b resp=%b required 0 1 00",
                         held_tran_op, HREADYOUTS, HRESPS);
    end
    set_idle(); readyout_dec = 1'b1; resp_dec = HRESP_OKAY;
    tick();
    HRESETn = 1'b1;
    tick();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rst_replay: observed %0d issues required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    active_dec = 1'b1; readyout_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h3000_0000 + 32'(i * 16), HTRANS_NONSEQ, 3'b000, 1'(i), $urandom);
      exp_q.push_back(cur);
      #1;
      n_checks++;
      if (HREADYOUTS !== 1'b1 || held_tran_op !== 1'b0) begin
        n_fail++; $display("FAIL b2b_beat%0d: observed ready=%b held=%b required 1 0",
                           i, HREADYOUTS, held_tran_op);
      end
      tick();
    end
    set_idle(); active_dec = 1'b0;
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_sb: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL b2b_sb: observed %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_extra: observed %0d extra required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_live();
    test_hold();
    test_seq_hold();
    test_error();
    test_busy_idle();
    test_reset_held();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
